// File: rtl/pattern_chk_pkg.sv
// Shared constants for the video pattern checker: pattern codes, ramp band geometry
// and the lock FSM encoding.
package pattern_chk_pkg;

   localparam logic [7:0] PAT_MOIRE_X = 8'd2;
   localparam logic [7:0] PAT_MOIRE_Y = 8'd3;
   localparam logic [7:0] PAT_RAMP    = 8'd4;

   localparam int BAND_H = 90;
   localparam int BAND_N = 8;
   localparam int BAND_W = $clog2(BAND_N);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      CHECK   = 2'd2
   } state_e;

   function automatic logic is_checked(input logic [7:0] pat);
      return (pat == PAT_MOIRE_X) || (pat == PAT_MOIRE_Y) || (pat == PAT_RAMP);
   endfunction

endpackage

// File: rtl/pattern_chk_expect.sv
// Expected pixel generator: maps (x, y, pattern, ramp accumulator) to the RGB value
// the source should be producing. Packed as [2]=blue, [1]=green, [0]=red.
module pattern_chk_expect
   import pattern_chk_pkg::*;
#(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int Y_BITS          = 13,
   parameter int FRACTIONAL_BITS = 12
) (
   input  logic [X_BITS-1:0]            x,
   input  logic [Y_BITS-1:0]            y,
   input  logic [7:0]                   pat,
   input  logic [B+FRACTIONAL_BITS-1:0] acc,
   output logic [2:0][B-1:0]            exp_rgb
);

   logic [B-1:0]      level;
   logic [BAND_W-1:0] band;
   logic              in_bands;
   logic              unused_bits;

   assign level       = acc[B+FRACTIONAL_BITS-1 -: B];
   assign unused_bits = ^{x[X_BITS-1:1], acc[FRACTIONAL_BITS-1:0]};

   always_comb begin
      // band = y / BAND_H as a threshold ladder; rows past the last band stay dark
      band = '0;
      for (int k = 1; k < BAND_N; k++)
         if (int'(y) >= k * BAND_H) band = BAND_W'(k);
      in_bands = int'(y) < BAND_N * BAND_H;

      exp_rgb = '0;
      case (pat)
         PAT_MOIRE_X: exp_rgb = {3{{B{x[0]}}}};
         PAT_MOIRE_Y: exp_rgb = {3{{B{y[0]}}}};
         PAT_RAMP: begin
            if (in_bands) begin
               exp_rgb[0] = band[0] ? level : '0;
               exp_rgb[1] = band[1] ? level : '0;
               exp_rgb[2] = band[2] ? level : '0;
            end
         end
         default: exp_rgb = '0;
      endcase
   end

endmodule

// File: rtl/pattern_chk.sv
// Video pattern checker: measures active frame geometry, locks onto stable
// dimensions and counts pixels that differ from the selected test pattern.
module pattern_chk
   import pattern_chk_pkg::*;
#(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int Y_BITS          = 13,
   parameter int FRACTIONAL_BITS = 12
) (
   input  logic                         clk_in,
   input  logic                         reset_n,
   input  logic                         vn_in,
   input  logic                         hn_in,
   input  logic                         dn_in,
   input  logic [B-1:0]                 r_in,
   input  logic [B-1:0]                 g_in,
   input  logic [B-1:0]                 b_in,
   input  logic [7:0]                   pattern,
   input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
   output logic [X_BITS-1:0]            meas_active_pix,
   output logic [Y_BITS-1:0]            meas_active_lines,
   output logic [15:0]                  err_count,
   output logic                         frame_done,
   output logic                         locked,
   output logic                         frame_pass
);

   localparam int AW = B + FRACTIONAL_BITS;

   state_e            state_q, state_d;
   logic              vn_q, vn_d, dn_q, dn_d;
   logic [X_BITS-1:0] x_q, x_d, last_w_q, last_w_d, meas_pix_q, meas_pix_d;
   logic [Y_BITS-1:0] y_q, y_d, meas_lines_q, meas_lines_d;
   logic [AW-1:0]     acc_q, acc_d, step_q, step_d;
   logic [7:0]        pat_q, pat_d;
   logic [15:0]       run_err_q, run_err_d, err_q, err_d;
   logic              done_q, done_d, locked_q, locked_d, pass_q, pass_d;

   logic              vn_fall, dn_fall, chk_en, dims_ok;
   logic [15:0]       err_next;
   logic [X_BITS-1:0] new_w;
   logic [Y_BITS-1:0] new_h;
   logic [2:0][B-1:0] exp_rgb;
   logic              unused_hn;

   assign unused_hn = hn_in;

   pattern_chk_expect #(
      .B(B), .X_BITS(X_BITS), .Y_BITS(Y_BITS), .FRACTIONAL_BITS(FRACTIONAL_BITS)
   ) u_expect (
      .x      (x_q),
      .y      (y_q),
      .pat    (pat_q),
      .acc    (acc_q),
      .exp_rgb(exp_rgb)
   );

   always_comb begin
      vn_d         = vn_in;
      dn_d         = dn_in;
      vn_fall      = vn_q & ~vn_in;
      dn_fall      = dn_q & ~dn_in;
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      acc_d        = acc_q;
      last_w_d     = last_w_q;
      pat_d        = pat_q;
      step_d       = step_q;
      meas_pix_d   = meas_pix_q;
      meas_lines_d = meas_lines_q;
      err_d        = err_q;
      done_d       = 1'b0;
      locked_d     = locked_q;
      pass_d       = pass_q;

      if (dn_fall) begin
         x_d      = '0;
         acc_d    = '0;
         y_d      = y_q + Y_BITS'(1);
         last_w_d = x_q;
      end else if (dn_in) begin
         x_d   = x_q + X_BITS'(1);
         acc_d = acc_q + step_q;
      end

      chk_en   = (state_q == CHECK) && dn_in && is_checked(pat_q);
      err_next = run_err_q;
      if (chk_en && (exp_rgb != {b_in, g_in, r_in}) && (run_err_q != 16'hFFFF))
         err_next = run_err_q + 16'd1;
      run_err_d = err_next;

      // a line ending on the vsync edge itself still counts toward this frame
      new_w   = dn_fall ? x_q : last_w_q;
      new_h   = y_q + Y_BITS'(dn_fall);
      dims_ok = (new_w != '0) && (new_h != '0);

      if (vn_fall) begin
         y_d          = '0;
         last_w_d     = '0;
         run_err_d    = '0;
         meas_pix_d   = new_w;
         meas_lines_d = new_h;
         err_d        = err_next;
         done_d       = 1'b1;
         pat_d        = pattern;
         step_d       = ramp_step;
         case (state_q)
            SEARCH:  state_d = ACQUIRE;
            ACQUIRE: if (dims_ok) state_d = CHECK;
            CHECK: begin
               if (!dims_ok || (new_w != meas_pix_q) || (new_h != meas_lines_q))
                  state_d = ACQUIRE;
            end
            default: state_d = SEARCH;
         endcase
         locked_d = (state_d == CHECK);
         pass_d   = locked_d && is_checked(pat_q) && (err_next == '0);
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= SEARCH;
         vn_q         <= 1'b0;
         dn_q         <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         acc_q        <= '0;
         last_w_q     <= '0;
         pat_q        <= '0;
         step_q       <= '0;
         run_err_q    <= '0;
         meas_pix_q   <= '0;
         meas_lines_q <= '0;
         err_q        <= '0;
         done_q       <= 1'b0;
         locked_q     <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vn_q         <= vn_d;
         dn_q         <= dn_d;
         x_q          <= x_d;
         y_q          <= y_d;
         acc_q        <= acc_d;
         last_w_q     <= last_w_d;
         pat_q        <= pat_d;
         step_q       <= step_d;
         run_err_q    <= run_err_d;
         meas_pix_q   <= meas_pix_d;
         meas_lines_q <= meas_lines_d;
         err_q        <= err_d;
         done_q       <= done_d;
         locked_q     <= locked_d;
         pass_q       <= pass_d;
      end
   end

   assign meas_active_pix   = meas_pix_q;
   assign meas_active_lines = meas_lines_q;
   assign err_count         = err_q;
   assign frame_done        = done_q;
   assign locked            = locked_q;
   assign frame_pass        = pass_q;

endmodule

// File: tb/tb_pattern_chk.sv
// Directed bench for pattern_chk: drives small synthetic frames and checks the
// per-frame measurement, lock and error outputs against hand-derived values.
module tb_pattern_chk;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        vn_in = 1'b1, hn_in = 1'b1, dn_in = 1'b0;
   logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
   logic [7:0]  pattern = '0;
   logic [19:0] ramp_step = '0;
   logic [12:0] meas_active_pix;
   logic [12:0] meas_active_lines;
   logic [15:0] err_count;
   logic        frame_done, locked, frame_pass;

   int n_chk = 0;
   int n_pass = 0;
   logic d0, d1;

   pattern_chk dut (
      .clk_in           (clk_in),
      .reset_n          (reset_n),
      .vn_in            (vn_in),
      .hn_in            (hn_in),
      .dn_in            (dn_in),
      .r_in             (r_in),
      .g_in             (g_in),
      .b_in             (b_in),
      .pattern          (pattern),
      .ramp_step        (ramp_step),
      .meas_active_pix  (meas_active_pix),
      .meas_active_lines(meas_active_lines),
      .err_count        (err_count),
      .frame_done       (frame_done),
      .locked           (locked),
      .frame_pass       (frame_pass)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // {b,g,r} the source should send for a pixel
   function automatic logic [23:0] model(input int x, input int y, input logic [7:0] pat,
                                         input logic [19:0] step);
      logic [7:0]  v;
      logic [7:0]  lvl;
      logic [19:0] acc;
      int          band;
      v = 8'h00;
      case (pat)
         8'd2: begin
            v = (x % 2 == 1) ? 8'hFF : 8'h00;
            return {v, v, v};
         end
         8'd3: begin
            v = (y % 2 == 1) ? 8'hFF : 8'h00;
            return {v, v, v};
         end
         8'd4: begin
            if (y >= 720) return 24'h0;
            acc  = 20'(x * int'(step));
            lvl  = acc[19:12];
            band = y / 90;
            return {((band / 4) % 2 == 1) ? lvl : 8'h00,
                    ((band / 2) % 2 == 1) ? lvl : 8'h00,
                    (band % 2 == 1)       ? lvl : 8'h00};
         end
         default: return 24'h0;
      endcase
   endfunction

   task automatic frame(input int w, input int h, input int blank, input int tail,
                        input int ovx, input int ovy, input logic [23:0] ovr, input bit inv);
      logic [23:0] pix;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            @(negedge clk_in);
            pix = model(x, y, pattern, ramp_step);
            if (inv) pix = ~pix;
            if (x == ovx && y == ovy) pix = ovr;
            dn_in = 1'b1;
            {b_in, g_in, r_in} = pix;
         end
         for (int i = 0; i < ((y == h - 1) ? tail : blank); i++) begin
            @(negedge clk_in);
            dn_in = 1'b0;
         end
      end
   endtask

   task automatic vsync(output logic done_at, output logic done_after);
      @(negedge clk_in);
      dn_in = 1'b0;
      vn_in = 1'b0;
      @(negedge clk_in);
      done_at = frame_done;
      @(negedge clk_in);
      done_after = frame_done;
      vn_in = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pix"}, 32'(meas_active_pix), 0);
      chk({tag, "_lines"}, 32'(meas_active_lines), 0);
      chk({tag, "_err"}, 32'(err_count), 0);
      chk({tag, "_done"}, 32'(frame_done), 0);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_pass"}, 32'(frame_pass), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      chk_zero("rst");
      reset_n = 1'b1;
      pattern = 8'd2;
      repeat (2) @(negedge clk_in);

      // first vsync only leaves SEARCH
      vsync(d0, d1);
      chk("v1_done", 32'(d0), 1);
      chk("v1_done_pulse", 32'(d1), 0);
      chk("v1_locked", 32'(locked), 0);
      chk("v1_pix", 32'(meas_active_pix), 0);

      frame(16, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("f1_done", 32'(d0), 1);
      chk("f1_pix", 32'(meas_active_pix), 16);
      chk("f1_lines", 32'(meas_active_lines), 12);
      chk("f1_locked", 32'(locked), 1);
      chk("f1_pass", 32'(frame_pass), 1);

      frame(16, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("f2_done", 32'(d0), 1);
      chk("f2_err", 32'(err_count), 0);
      chk("f2_pass", 32'(frame_pass), 1);

      // single bad pixel at odd x, switch to moireY for the following frame
      frame(16, 12, 2, 2, 5, 3, 24'h0, 1'b0);
      pattern = 8'd3;
      vsync(d0, d1);
      chk("f3_err", 32'(err_count), 1);
      chk("f3_pass", 32'(frame_pass), 0);
      chk("f3_locked", 32'(locked), 1);

      frame(16, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("moy_err", 32'(err_count), 0);
      chk("moy_pass", 32'(frame_pass), 1);

      // last line ends on the same cycle as the vsync edge
      frame(16, 12, 2, 0, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("edge_pix", 32'(meas_active_pix), 16);
      chk("edge_lines", 32'(meas_active_lines), 12);
      chk("edge_locked", 32'(locked), 1);

      frame(24, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("wide1_pix", 32'(meas_active_pix), 24);
      chk("wide1_locked", 32'(locked), 0);
      chk("wide1_err", 32'(err_count), 0);

      frame(24, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("wide2_locked", 32'(locked), 1);
      chk("wide2_pix", 32'(meas_active_pix), 24);

      vsync(d0, d1);
      chk("empty_pix", 32'(meas_active_pix), 0);
      chk("empty_lines", 32'(meas_active_lines), 0);
      chk("empty_locked", 32'(locked), 0);

      frame(16, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("relock", 32'(locked), 1);

      // reset in the middle of a frame
      frame(16, 6, 2, 2, -1, -1, 24'h0, 1'b0);
      @(negedge clk_in);
      reset_n = 1'b0;
      @(negedge clk_in);
      chk_zero("mid_rst");
      reset_n = 1'b1;
      frame(16, 6, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("post_rst1_done", 32'(d0), 1);
      chk("post_rst1_locked", 32'(locked), 0);
      chk("post_rst1_lines", 32'(meas_active_lines), 6);

      frame(16, 12, 2, 2, -1, -1, 24'h0, 1'b0);
      pattern   = 8'd4;
      ramp_step = 20'h00C00;
      vsync(d0, d1);
      chk("post_rst2_locked", 32'(locked), 1);

      // ramp frames, first one checked against the previous lock
      frame(16, 100, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("ramp1_err", 32'(err_count), 0);
      chk("ramp1_lines", 32'(meas_active_lines), 100);
      chk("ramp1_locked", 32'(locked), 0);

      frame(16, 100, 2, 2, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("ramp2_locked", 32'(locked), 1);

      frame(16, 100, 2, 2, 10, 95, 24'h000008, 1'b0);
      vsync(d0, d1);
      chk("ramp_red8_err", 32'(err_count), 1);
      chk("ramp_red8_pass", 32'(frame_pass), 0);

      frame(16, 100, 2, 2, 10, 95, 24'h000707, 1'b0);
      vsync(d0, d1);
      chk("ramp_green_err", 32'(err_count), 1);

      // tall frame reaches rows past the last band
      frame(4, 724, 1, 1, 3, 722, 24'h000001, 1'b0);
      pattern = 8'd2;
      vsync(d0, d1);
      chk("tall_err", 32'(err_count), 1);
      chk("tall_lines", 32'(meas_active_lines), 724);
      chk("tall_pix", 32'(meas_active_pix), 4);
      chk("tall_locked", 32'(locked), 0);

      frame(4, 4, 1, 1, -1, -1, 24'h0, 1'b0);
      vsync(d0, d1);
      chk("pre_sat_locked", 32'(locked), 1);

      // every pixel wrong, more than 65535 of them
      frame(256, 257, 1, 1, -1, -1, 24'h0, 1'b1);
      vsync(d0, d1);
      chk("sat_err", 32'(err_count), 32'hFFFF);
      chk("sat_pass", 32'(frame_pass), 0);
      chk("sat_lines", 32'(meas_active_lines), 257);
      chk("sat_pix", 32'(meas_active_pix), 256);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
